// File: rtl/reveal_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : reveal_sched_if
//  Description : Bundle between the reveal scheduler, the frame timing
//                generator, the string ROM and the raster datapath.
//                  fe   - frame-end strobe (one cycle)
//                  en   - run enable
//                  ra   - string ROM read index (scheduler -> ROM)
//                  rc   - character at ra, same cycle (ROM -> scheduler)
//                  lim  - published count of visible characters
//                  top  - published index of the first character on row 0
//                  done - high while the full text is being held
//                Modport slave is the scheduler side; master is everything
//                around it.
//  Revision    : 1.0  initial release
// ============================================================================
interface reveal_sched_if #(
  parameter int AW = 8
);
  logic          fe;
  logic          en;
  logic [AW-1:0] ra;
  logic [7:0]    rc;
  logic [AW-1:0] lim;
  logic [AW-1:0] top;
  logic          done;

  modport master (output fe, en, rc, input ra, lim, top, done);
  modport slave  (input fe, en, rc, output ra, lim, top, done);
endinterface
`default_nettype wire

// File: rtl/reveal_sched.sv
`default_nettype none
// ============================================================================
//  Module      : reveal_sched
//  Description : Typewriter reveal scheduler. Once per frame decides how many
//                characters of the source string are visible (lim) and which
//                index starts screen row 0 (top). Both outputs only change on
//                an accepted frame-end strobe.
//  Ports       : k      - pixel clock, all logic on its rising edge
//                rst_n  - synchronous active-low reset
//                bus    - reveal_sched_if.slave (fe, en, ra, rc, lim, top, done)
//  Config      : REVEAL_SCROLL_EN - when defined, newlines are counted and the
//                text scrolls by whole lines once ROWS lines are full. When
//                undefined, top is tied to 0 and overflow falls off screen.
//  Revision    : 1.0  initial release
// ============================================================================
module reveal_sched #(
  parameter int N    = 161,
  parameter int FPC  = 2,
  parameter int HOLD = 120,
  parameter int ROWS = 53,
  parameter int AW   = $clog2(N + 1)
) (
  input  wire logic     k,
  input  wire logic     rst_n,
  reveal_sched_if.slave bus
);

  localparam int FCW = (FPC  > 1) ? $clog2(FPC)  : 1;
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [1:0] S_TYPE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [7:0] NEWLINE = 8'd88;

  if (N < 1 || FPC < 1 || HOLD < 1 || ROWS < 1) begin : g_cfg_bad
    $error("reveal_sched: N, FPC, HOLD and ROWS must all be at least 1");
  end

  logic [1:0]     state_q, state_d;
  logic [AW-1:0]  wl_q, wl_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic [HCW-1:0] hc_q, hc_d;
  logic [AW-1:0]  lim_q, lim_d;
  logic           done_q, done_d;
  logic           take;
  logic [AW-1:0]  wl_inc;

  // wl never passes N: reaching N moves to HOLD before another increment.
  assign wl_inc = (wl_q == AW'(N)) ? wl_q : wl_q + AW'(1);

`ifdef REVEAL_SCROLL_EN
  localparam int LNW = $clog2(ROWS + 1);
  localparam logic [1:0] S_SCAN = 2'd1;

  logic [AW-1:0]  wt_q, wt_d;
  logic [AW-1:0]  top_q, top_d;
  logic [AW-1:0]  sp_q, sp_d;
  logic [LNW-1:0] ln_q, ln_d;
  logic           pend_q, pend_d;
  logic [LNW-1:0] ln_new;

  assign bus.ra  = (state_q == S_SCAN) ? sp_q : wl_q;
  assign bus.top = top_q;
`else
  assign bus.ra  = wl_q;
  assign bus.top = '0;
`endif

  assign bus.lim  = lim_q;
  assign bus.done = done_q;

  always_comb begin
    state_d = state_q;
    wl_d    = wl_q;
    fc_d    = fc_q;
    hc_d    = hc_q;
    lim_d   = lim_q;
    take    = 1'b0;
    done_d  = (state_q == S_HOLD);
`ifdef REVEAL_SCROLL_EN
    wt_d    = wt_q;
    top_d   = top_q;
    sp_d    = sp_q;
    ln_d    = ln_q;
    pend_d  = pend_q;
    ln_new  = ln_q;
`endif

    if (bus.en) begin
      case (state_q)
        S_TYPE: begin
`ifdef REVEAL_SCROLL_EN
          // A strobe deferred during SCAN is handled here as if it just arrived.
          take   = bus.fe | pend_q;
          pend_d = 1'b0;
`else
          take   = bus.fe;
`endif
          if (take) begin
            lim_d = wl_q;
`ifdef REVEAL_SCROLL_EN
            top_d = wt_q;
`endif
            if (fc_q == FCW'(FPC - 1)) begin
              fc_d = '0;
              wl_d = wl_inc;
`ifdef REVEAL_SCROLL_EN
              // rc is the character at ra=wl, i.e. the one being revealed now.
              if (bus.rc == NEWLINE && ln_q != LNW'(ROWS))
                ln_new = ln_q + LNW'(1);
              ln_d = ln_new;
`endif
              if (wl_inc == AW'(N)) begin
                state_d = S_HOLD;
                hc_d    = '0;
              end
`ifdef REVEAL_SCROLL_EN
              else if (ln_new == LNW'(ROWS)) begin
                state_d = S_SCAN;
                sp_d    = wt_q;
              end
`endif
            end else begin
              fc_d = fc_q + FCW'(1);
            end
          end
        end

`ifdef REVEAL_SCROLL_EN
        S_SCAN: begin
          if (bus.fe)
            pend_d = 1'b1;
          if (bus.rc == NEWLINE) begin
            // Drop the first visible line: row 0 now starts after this newline.
            wt_d    = sp_q + AW'(1);
            ln_d    = LNW'(ROWS - 1);
            state_d = S_TYPE;
          end else if (sp_q + AW'(1) >= wl_q) begin
            // No newline before the reveal point; keep top where it is.
            ln_d    = LNW'(ROWS - 1);
            state_d = S_TYPE;
          end else if (sp_q != AW'(N - 1)) begin
            sp_d = sp_q + AW'(1);
          end
        end
`endif

        S_HOLD: begin
          if (bus.fe) begin
            lim_d = wl_q;
`ifdef REVEAL_SCROLL_EN
            top_d = wt_q;
`endif
            if (hc_q == HCW'(HOLD - 1)) begin
              wl_d    = '0;
              fc_d    = '0;
              state_d = S_TYPE;
`ifdef REVEAL_SCROLL_EN
              wt_d    = '0;
              ln_d    = '0;
`endif
            end else begin
              hc_d = hc_q + HCW'(1);
            end
          end
        end

        default: state_d = S_TYPE;
      endcase
    end
  end

  always_ff @(posedge k) begin
    if (!rst_n) begin
      state_q <= S_TYPE;
      wl_q    <= '0;
      fc_q    <= '0;
      hc_q    <= '0;
      lim_q   <= '0;
      done_q  <= 1'b0;
`ifdef REVEAL_SCROLL_EN
      wt_q    <= '0;
      top_q   <= '0;
      sp_q    <= '0;
      ln_q    <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wl_q    <= wl_d;
      fc_q    <= fc_d;
      hc_q    <= hc_d;
      lim_q   <= lim_d;
      done_q  <= done_d;
`ifdef REVEAL_SCROLL_EN
      wt_q    <= wt_d;
      top_q   <= top_d;
      sp_q    <= sp_d;
      ln_q    <= ln_d;
      pend_q  <= pend_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reveal_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reveal_sched
//  Description : Directed bench for reveal_sched. Three instances share clock,
//                reset, fe and en:
//                  u_rate - N=10, FPC=2, string without newlines
//                  u_scr  - N=10, FPC=1, ROWS=2, string "aXbXcXdddd"
//                  u_hold - N=4,  FPC=1, HOLD=3
//                Expected values that depend on REVEAL_SCROLL_EN are chosen
//                with the same macro.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reveal_sched;

  logic k = 1'b0;
  logic rst_n = 1'b0;
  logic fe = 1'b0;
  logic en = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0] rom_r [0:9];
  logic [7:0] rom_s [0:9];
  logic [7:0] rom_h [0:3];

  always #5 k = ~k;

  reveal_sched_if #(.AW(4)) if_r ();
  reveal_sched_if #(.AW(4)) if_s ();
  reveal_sched_if #(.AW(3)) if_h ();

  assign if_r.fe = fe;
  assign if_r.en = en;
  assign if_s.fe = fe;
  assign if_s.en = en;
  assign if_h.fe = fe;
  assign if_h.en = en;
  assign if_r.rc = (if_r.ra < 4'd10) ? rom_r[if_r.ra] : 8'h20;
  assign if_s.rc = (if_s.ra < 4'd10) ? rom_s[if_s.ra] : 8'h20;
  assign if_h.rc = (if_h.ra < 3'd4)  ? rom_h[if_h.ra[1:0]] : 8'h20;

  reveal_sched #(.N(10), .FPC(2), .HOLD(4), .ROWS(53), .AW(4)) u_rate (
    .k(k), .rst_n(rst_n), .bus(if_r.slave));
  reveal_sched #(.N(10), .FPC(1), .HOLD(4), .ROWS(2), .AW(4)) u_scr (
    .k(k), .rst_n(rst_n), .bus(if_s.slave));
  reveal_sched #(.N(4), .FPC(1), .HOLD(3), .ROWS(53), .AW(3)) u_hold (
    .k(k), .rst_n(rst_n), .bus(if_h.slave));

  // fe is high across exactly one rising edge; returns on the following
  // falling edge so outputs can be sampled right away.
  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge k) fe = 1'b1;
      @(negedge k) fe = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge k) rst_n = 1'b0;
    @(negedge k) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge k) fe = 1'b1;
    @(negedge k) fe = 1'b0;
    @(negedge k) fe = 1'b1;
    @(negedge k) fe = 1'b0;
    total++; if (if_r.lim !== 4'd0 || if_r.top !== 4'd0 || if_r.done !== 1'b0 || if_r.ra !== 4'd0) begin
      bad++; $display("FAIL reset_rate: lim=%0d top=%0d done=%0d ra=%0d required all 0", if_r.lim, if_r.top, if_r.done, if_r.ra); end
    total++; if (if_s.lim !== 4'd0 || if_s.top !== 4'd0 || if_s.done !== 1'b0 || if_s.ra !== 4'd0) begin
      bad++; $display("FAIL reset_scr: lim=%0d top=%0d done=%0d ra=%0d required all 0", if_s.lim, if_s.top, if_s.done, if_s.ra); end
    total++; if (if_h.lim !== 3'd0 || if_h.top !== 3'd0 || if_h.done !== 1'b0 || if_h.ra !== 3'd0) begin
      bad++; $display("FAIL reset_hold: lim=%0d top=%0d done=%0d ra=%0d required all 0", if_h.lim, if_h.top, if_h.done, if_h.ra); end
    @(negedge k) rst_n = 1'b1;
  endtask

  task automatic test_rate();
    do_reset();
    pulse(2);
    total++; if (if_r.ra !== 4'd1 || if_r.lim !== 4'd0) begin
      bad++; $display("FAIL rate_2fe: ra=%0d lim=%0d required ra=1 lim=0", if_r.ra, if_r.lim); end
    pulse(4);
    total++; if (if_r.ra !== 4'd3) begin
      bad++; $display("FAIL rate_wl: got %0d required 3", if_r.ra); end
    total++; if (if_r.lim !== 4'd2) begin
      bad++; $display("FAIL rate_lim: got %0d required 2", if_r.lim); end
    total++; if (if_r.top !== 4'd0 || if_r.done !== 1'b0) begin
      bad++; $display("FAIL rate_top_done: top=%0d done=%0d required 0 0", if_r.top, if_r.done); end
  endtask

  task automatic test_scroll();
    int exp_ra0, exp_ra1, exp_top;
`ifdef REVEAL_SCROLL_EN
    exp_ra0 = 0; exp_ra1 = 1; exp_top = 2;
`else
    exp_ra0 = 4; exp_ra1 = 4; exp_top = 0;
`endif
    do_reset();
    pulse(4);
    total++; if (if_s.ra !== 4'(exp_ra0)) begin
      bad++; $display("FAIL scroll_read0: ra=%0d required %0d", if_s.ra, exp_ra0); end
    @(negedge k);
    total++; if (if_s.ra !== 4'(exp_ra1)) begin
      bad++; $display("FAIL scroll_read1: ra=%0d required %0d", if_s.ra, exp_ra1); end
    @(negedge k);
    total++; if (if_s.ra !== 4'd4 || if_s.top !== 4'd0) begin
      bad++; $display("FAIL scroll_back: ra=%0d top=%0d required ra=4 top=0", if_s.ra, if_s.top); end
    pulse(1);
    total++; if (if_s.top !== 4'(exp_top) || if_s.lim !== 4'd4) begin
      bad++; $display("FAIL scroll_publish: top=%0d lim=%0d required top=%0d lim=4", if_s.top, if_s.lim, exp_top); end
  endtask

  task automatic test_fe_in_scan();
    int exp_top;
`ifdef REVEAL_SCROLL_EN
    exp_top = 2;
`else
    exp_top = 0;
`endif
    do_reset();
    pulse(4);
    fe = 1'b1;
    @(negedge k) fe = 1'b0;
    @(negedge k);
    @(negedge k);
    total++; if (if_s.lim !== 4'd4 || if_s.ra !== 4'd5) begin
      bad++; $display("FAIL pend_lim_wl: lim=%0d wl=%0d required lim=4 wl=5", if_s.lim, if_s.ra); end
    total++; if (if_s.top !== 4'(exp_top)) begin
      bad++; $display("FAIL pend_top: got %0d required %0d", if_s.top, exp_top); end
  endtask

  task automatic test_hold();
    do_reset();
    pulse(4);
    total++; if (if_h.lim !== 3'd3 || if_h.ra !== 3'd4) begin
      bad++; $display("FAIL hold_entry: lim=%0d ra=%0d required lim=3 ra=4", if_h.lim, if_h.ra); end
    @(negedge k);
    total++; if (if_h.done !== 1'b1) begin
      bad++; $display("FAIL hold_done_rise: got %0d required 1", if_h.done); end
    pulse(2);
    total++; if (if_h.done !== 1'b1 || if_h.ra !== 3'd4 || if_h.lim !== 3'd4) begin
      bad++; $display("FAIL hold_mid: done=%0d ra=%0d lim=%0d required 1 4 4", if_h.done, if_h.ra, if_h.lim); end
    pulse(1);
    @(negedge k);
    total++; if (if_h.done !== 1'b0 || if_h.ra !== 3'd0 || if_h.top !== 3'd0) begin
      bad++; $display("FAIL hold_restart: done=%0d wl=%0d top=%0d required 0 0 0", if_h.done, if_h.ra, if_h.top); end
    total++; if (if_h.lim !== 3'd4) begin
      bad++; $display("FAIL hold_last_pub: lim=%0d required 4", if_h.lim); end
    pulse(1);
    total++; if (if_h.lim !== 3'd0) begin
      bad++; $display("FAIL hold_pub_zero: lim=%0d required 0", if_h.lim); end
  endtask

  task automatic test_freeze();
    do_reset();
    pulse(3);
    en = 1'b0;
    pulse(5);
    total++; if (if_r.ra !== 4'd1 || if_r.lim !== 4'd1) begin
      bad++; $display("FAIL freeze_hold: wl=%0d lim=%0d required 1 1", if_r.ra, if_r.lim); end
    en = 1'b1;
    pulse(1);
    total++; if (if_r.ra !== 4'd2 || if_r.lim !== 4'd1) begin
      bad++; $display("FAIL freeze_resume: wl=%0d lim=%0d required 2 1", if_r.ra, if_r.lim); end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    pulse(4);
    rst_n = 1'b0;
    @(negedge k);
    total++; if (if_s.ra !== 4'd0 || if_s.lim !== 4'd0 || if_s.top !== 4'd0) begin
      bad++; $display("FAIL abort_reset: ra=%0d lim=%0d top=%0d required 0 0 0", if_s.ra, if_s.lim, if_s.top); end
    rst_n = 1'b1;
    @(negedge k);
    total++; if (if_s.ra !== 4'd0) begin
      bad++; $display("FAIL abort_idle: ra=%0d required 0", if_s.ra); end
    pulse(1);
    total++; if (if_s.ra !== 4'd1 || if_s.lim !== 4'd0) begin
      bad++; $display("FAIL abort_restart: ra=%0d lim=%0d required 1 0", if_s.ra, if_s.lim); end
  endtask

  initial begin
    string sr, ss, sh;
    sr = "abcdefghij";
    ss = "aXbXcXdddd";
    sh = "abcd";
    for (int i = 0; i < 10; i++) begin
      rom_r[i] = sr[i];
      rom_s[i] = ss[i];
    end
    for (int i = 0; i < 4; i++) rom_h[i] = sh[i];

    test_reset();
    test_rate();
    test_scroll();
    test_fe_in_scan();
    test_hold();
    test_freeze();
    test_reset_mid_scan();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reveal_sched.md
# reveal_sched

Typewriter reveal scheduler for the self-displaying text raster. Once per frame it decides how many characters of the stored source string are visible and which character index starts screen row 0. When the revealed text overflows the screen it scrolls by whole lines, finding line starts through its own read port on the string ROM. The raster datapath blanks cells with index ≥ `lim` and begins its character walk at `top`. Both values change only at frame boundaries, so no frame ever shows a partial update.

## Interface
- `N`, 161: string length in characters.
- `FPC`, 2: frames per revealed character (≥1).
- `HOLD`, 120: frames to hold the full text before restarting (≥1).
- `ROWS`, 53: visible text rows (480/9).
- `AW`, $clog2(N+1): index width.

- `k`  in  1: pixel clock. One clock; all logic on posedge `k`.
- `rst_n`  in  1: synchronous, active-low reset.
- `fe`  in  1: frame-end strobe, one cycle high when x==799 && y==524.
- `en`  in  1: run enable. When low, all counters and state freeze; `fe` is ignored.
- `ra`  out  AW: string ROM read index (combinational).
- `rc`  in  8: character at `ra`, returned the same cycle. Code 88 ("X") means newline.
- `lim`  out  AW: published count of visible characters.
- `top`  out  AW: published index of the first character on row 0.
- `done`  out  1: high while in HOLD.

## Operation
- Working registers: `wl` (lim), `wt` (top), `ln` (completed newlines shown, 0..ROWS), `fc` (frame counter), `hc` (hold counter), `sp` (scan pointer), `pend`.
- States:
  - TYPE (the reset state).
  - SCAN.
  - HOLD.
- `ra` = `sp` in SCAN, otherwise `wl`.
- Publish rule: on every accepted `fe`, `lim`/`top` load `wl`/`wt` as they stood before that same `fe` updates them.
- TYPE, on accepted `fe`:
  - If `fc`==FPC-1: `fc`←0 and `wl`←`wl`+1.
  - If `rc`==88 at that cycle (this is the character being revealed), `ln`←`ln`+1.
  - If the new `ln`==ROWS: go to SCAN with `sp`←`wt`.
  - If the new `wl`==N: go to HOLD with `hc`←0. HOLD takes priority over SCAN.
  - Otherwise `fc`←`fc`+1.
- SCAN, one ROM read per cycle:
  - If `rc`==88: `wt`←`sp`+1, `ln`←ROWS-1, return to TYPE.
  - Otherwise `sp`←`sp`+1.
  - If `sp` reaches `wl` without a newline (cannot happen with consistent data), return to TYPE with `wt` unchanged and `ln`←ROWS-1.
- `fe` arriving in SCAN sets `pend`. The deferred `fe` is processed on the first TYPE cycle, including its publish, then `pend` clears.
- HOLD, on accepted `fe`:
  - If `hc`==HOLD-1: `wl`←0, `wt`←0, `ln`←0, `fc`←0, go to TYPE.
  - Otherwise `hc`←`hc`+1.
- Arithmetic: all indices are unsigned AW bits. `wl` never exceeds N and `sp` never exceeds N-1 (saturate; no wrap).

## Timing
- Reset (`rst_n` low at posedge) clears everything on that edge:
  - `lim`=0, `top`=0, `done`=0, `ra`=0.
  - State TYPE; `fc`=`ln`=`hc`=`pend`=0.
- Reset mid-SCAN or mid-HOLD aborts immediately; there is no partial commit.
- Display latency: a change to `wl`/`wt` at frame f appears on `lim`/`top` at the `fe` of frame f+1.
- SCAN takes at most N cycles, far shorter than one frame.
- `done` is registered; it rises the cycle after HOLD is entered and falls the cycle after HOLD is left.
- `fe` while `en`=0: no publish, no state change.

## Configuration
- `REVEAL_SCROLL_EN` defined: newline counting and the SCAN state are built in, with behaviour as above.
- `REVEAL_SCROLL_EN` undefined: no `ln`, `sp`, SCAN or `pend`.
  - `wt` and `top` are tied to 0 and `ra`=`wl`.
  - Text beyond row ROWS simply falls off screen.
  - TYPE/HOLD behaviour is otherwise identical.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `fe` pulsing → `lim`=0, `top`=0, `done`=0, `ra`=0.
- Reveal rate: FPC=2, `en`=1, string without "X", 6 `fe` pulses → `wl`=3 and `lim`=2 after the 6th `fe`.
- Scroll (macro on): ROWS=2, FPC=1, string "aXbXcXdd…", 4 `fe` → SCAN reads indices 0 and 1 over 2 cycles, `wt`=2, `ln`=1. The next `fe` publishes `top`=2 and `lim`=4.
- `fe` during SCAN: same setup, inject `fe` on the first SCAN cycle → `pend`=1, processed on return to TYPE, `lim`=4, `wl`=5.
- Hold/restart: N=4, FPC=1, HOLD=3 → `done`=1 one cycle after the 4th `fe`. After 3 further `fe`, `wl`=0 and `wt`=0, `done`=0, and the next `fe` publishes `lim`=0.
- Freeze and abort: `en`=0 for 5 `fe` → no change. `rst_n`=0 mid-SCAN → all reset on the next edge. Macro off with the scroll string → `top` stays 0.
